lead_one_normalizer: RTL
========================

// Module: lead_one_normalizer
// PURPOSE
//  Parametrised, pipelined float-mantissa normaliser. It locates the leading one of an unsigned
//  WIDTH-bit mantissa, left-shifts the mantissa so that one lands in the MSB, and decrements the
//  exponent by the shift amount. It sits between the add/sub datapath and the rounder in the
//  float unit, and uses valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  16  mantissa width in bits; must be >= 2
//  EXP_W  8   exponent width in bits; unsigned, biased exponent
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input beat present
//  in_ready   out  1        block can accept a beat this cycle
//  in_mant    in   WIDTH    unnormalised mantissa
//  in_exp     in   EXP_W    exponent belonging to in_mant
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts the result
//  out_mant   out  WIDTH    normalised mantissa
//  out_exp    out  EXP_W    adjusted exponent
//  out_idx    out  IDX_W    bit position of the leading one (IDX_W = clog2(WIDTH))
//  out_zero   out  1        in_mant was all zeros
//  out_uflow  out  1        the exponent could not absorb the full shift
// BEHAVIOUR
//  - Handshake: a beat transfers when valid and ready are both high at a clk edge.
//    out_valid/out_* hold stable until accepted; out_valid must not depend on out_ready.
//  - Pipeline: two register stages, S1 and S2. Latency is 2 cycles from acceptance to
//    out_valid with no stall. Throughput is 1 beat per cycle. At most 2 beats are in flight.
//  - S1: priority-encode in_mant to idx, the highest set bit; ties are impossible. Register
//    idx, zero, mant and exp.
//  - S2: compute shift = WIDTH-1-idx.
//      - If zero: mant=0, exp=0, idx=0, uflow=0.
//      - Else if shift <= exp: mant = mant << shift, exp = exp - shift, uflow = 0.
//      - Else: mant = mant << exp (denormal result), exp = 0, uflow = 1.
//    The subtraction is unsigned EXP_W-bit and never wraps.
//  - Stall rules:
//      - S2 loads when it is empty or out_ready is high.
//      - S1 loads when it is empty or S2 loads.
//      - in_ready = !s1_valid | s2_load. This is combinational from out_ready, with no
//        extra buffering.
//      - Bubbles collapse: an empty S2 is refilled from S1 even while out_ready is low.
//  - Simultaneous accept on both sides with a full pipe: everything shifts one stage and
//    in_ready stays high.
//  - Reset, asynchronous and valid mid-operation: all in-flight beats are discarded.
//    s1_valid = s2_valid = 0, out_valid = 0, out_mant = 0, out_exp = 0, out_idx = 0,
//    out_zero = 0, out_uflow = 0. in_ready = 1 from the first cycle after deassertion.
//  - Data registers hold their value when the stage valid is low; no X propagates to out_*.
// CONFIGURATION
//  LON_STATS_EN defined:
//    - Adds output ports stat_beats [31:0] and stat_zero [31:0].
//    - stat_beats counts output transfers; stat_zero counts output transfers with out_zero=1.
//    - Both counters saturate at 32'hFFFF_FFFF, clear on rst_n, and add 1 cycle of count
//      latency relative to the transfer.
//  LON_STATS_EN undefined: the ports and counters do not exist. Datapath timing is identical
//    in both builds.
// STRUCTURE
//  - Package fc_norm_pkg holds:
//      - function clog2
//      - localparam IDX_W derivation helper
//      - typedef norm_beat_t {mant, exp, idx, zero, uflow}, shared with the rounder
//  - Sub-module prio_enc_param #(WIDTH):
//      - Combinational; outputs idx[IDX_W] and zero.
//      - Highest set bit wins; all-zero input gives idx=0, zero=1.
//      - Instantiated once, in S1.
//  - The shifter and exponent adjust are inline in S2. There is no separate state machine;
//    control is the two stage-valid bits.
// TESTING (WIDTH=16, EXP_W=8)
//  1. mant=16'h0010, exp=20 -> after 2 cycles: idx=4, mant=16'h8000, exp=9, zero=0, uflow=0.
//  2. mant=16'h0001, exp=5 -> shift 15 > 5: mant=16'h0020, exp=0, uflow=1, idx=0.
//  3. mant=16'h8000, exp=0 -> mant=16'h8000, exp=0, idx=15, uflow=0.
//     mant=16'h0000, exp=37 -> zero=1, mant=0, exp=0, uflow=0.
//  4. Backpressure:
//     - out_ready=0, stream A, B, C back-to-back.
//     - Required: A and B accepted, in_ready=0 while C is offered, outputs stable.
//     - Raise out_ready: A, B, C emerge in order on consecutive cycles, with no drop and no
//       duplicate.
//  5. Streaming 100 random beats with out_ready=1 -> one result per cycle after 2-cycle fill.
//     Results match the reference model bit-exactly.
//  6. Assert rst_n low while 2 beats are in flight -> out_valid=0 immediately and all outputs
//     are 0. After release: in_ready=1 and no stale beat emerges.
//     With LON_STATS_EN: after test 3, stat_beats=2 and stat_zero=1.

Source files
------------

// File: rtl/lead_one_normalizer_pkg.sv
// Shared types and sizing helpers for the float normaliser and rounder.
// Holds clog2, index-width derivation and the normalised beat bundle.
package fc_norm_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // An index bus is never narrower than one bit.
   function automatic int idx_width(input int w);
      return (clog2(w) < 1) ? 1 : clog2(w);
   endfunction

   localparam int NORM_MANT_W = 16;
   localparam int NORM_EXP_W  = 8;
   localparam int NORM_IDX_W  = idx_width(NORM_MANT_W);

   typedef struct packed {
      logic [NORM_MANT_W-1:0] mant;
      logic [NORM_EXP_W-1:0]  exp;
      logic [NORM_IDX_W-1:0]  idx;
      logic                   zero;
      logic                   uflow;
   } norm_beat_t;

endpackage

// File: rtl/lead_one_normalizer_prio_enc.sv
// Leading-one priority encoder: highest set bit wins.
// All-zero input reports idx=0 with zero=1.
module prio_enc_param
   import fc_norm_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int IDX_W = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] mant_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             zero_o
);

   // Scan upward so the last (highest) set bit overrides lower ones.
   always_comb begin
      idx_o  = '0;
      zero_o = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (mant_i[i]) begin
            idx_o  = IDX_W'(i);
            zero_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/lead_one_normalizer.sv
// Two-stage pipelined mantissa normaliser with valid/ready on both sides.
// Optional LON_STATS_EN adds saturating output-transfer counters.
module lead_one_normalizer
   import fc_norm_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int EXP_W = 8,
   localparam int IDX_W = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mant,
   input  logic [EXP_W-1:0] in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mant,
   output logic [EXP_W-1:0] out_exp,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_zero,
   output logic             out_uflow
`ifdef LON_STATS_EN
   ,
   output logic [31:0]      stat_beats,
   output logic [31:0]      stat_zero
`endif
);

   // Compare width wide enough for both the shift and the exponent.
   localparam int CW = ((IDX_W > EXP_W) ? IDX_W : EXP_W) + 1;

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_mant_q;
   logic [EXP_W-1:0] s1_exp_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic             s1_zero_q;

   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_mant_q;
   logic [EXP_W-1:0] s2_exp_q;
   logic [IDX_W-1:0] s2_idx_q;
   logic             s2_zero_q;
   logic             s2_uflow_q;

   logic [WIDTH-1:0] s2_mant_d;
   logic [EXP_W-1:0] s2_exp_d;
   logic [IDX_W-1:0] s2_idx_d;
   logic             s2_zero_d;
   logic             s2_uflow_d;

   logic [IDX_W-1:0] enc_idx;
   logic             enc_zero;
   logic [CW-1:0]    shift_c;
   logic [CW-1:0]    exp_c;

   logic s2_load;
   logic s1_load;
   logic in_fire;

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;
   assign in_fire  = in_valid && in_ready;

   prio_enc_param #(
      .WIDTH (WIDTH)
   ) u_enc (
      .mant_i (in_mant),
      .idx_o  (enc_idx),
      .zero_o (enc_zero)
   );

   // S1: capture the encoded beat; data only moves on a real transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mant_q  <= '0;
         s1_exp_q   <= '0;
         s1_idx_q   <= '0;
         s1_zero_q  <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid_q <= in_valid;
         end
         if (in_fire) begin
            s1_mant_q <= in_mant;
            s1_exp_q  <= in_exp;
            s1_idx_q  <= enc_idx;
            s1_zero_q <= enc_zero;
         end
      end
   end

   // S2 datapath: shift toward the MSB as far as the exponent allows.
   always_comb begin
      shift_c    = CW'(WIDTH - 1) - CW'(s1_idx_q);
      exp_c      = CW'(s1_exp_q);
      s2_mant_d  = '0;
      s2_exp_d   = '0;
      s2_idx_d   = '0;
      s2_zero_d  = 1'b0;
      s2_uflow_d = 1'b0;
      if (s1_zero_q) begin
         s2_zero_d = 1'b1;
      end else if (shift_c <= exp_c) begin
         s2_mant_d = s1_mant_q << shift_c;
         s2_exp_d  = s1_exp_q - shift_c[EXP_W-1:0];
         s2_idx_d  = s1_idx_q;
      end else begin
         s2_mant_d  = s1_mant_q << s1_exp_q;
         s2_idx_d   = s1_idx_q;
         s2_uflow_d = 1'b1;
      end
   end

   // S2: output register; refills from S1 whenever it is free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_mant_q  <= '0;
         s2_exp_q   <= '0;
         s2_idx_q   <= '0;
         s2_zero_q  <= 1'b0;
         s2_uflow_q <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_mant_q  <= s2_mant_d;
            s2_exp_q   <= s2_exp_d;
            s2_idx_q   <= s2_idx_d;
            s2_zero_q  <= s2_zero_d;
            s2_uflow_q <= s2_uflow_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_mant  = s2_mant_q;
   assign out_exp   = s2_exp_q;
   assign out_idx   = s2_idx_q;
   assign out_zero  = s2_zero_q;
   assign out_uflow = s2_uflow_q;

`ifdef LON_STATS_EN
   logic [31:0] beats_q;
   logic [31:0] zeros_q;
   logic        out_fire;

   assign out_fire = s2_valid_q && out_ready;

   // Saturating counters of delivered beats and zero results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats_q <= '0;
         zeros_q <= '0;
      end else if (out_fire) begin
         if (beats_q != 32'hFFFF_FFFF) begin
            beats_q <= beats_q + 32'd1;
         end
         if (s2_zero_q && (zeros_q != 32'hFFFF_FFFF)) begin
            zeros_q <= zeros_q + 32'd1;
         end
      end
   end

   assign stat_beats = beats_q;
   assign stat_zero  = zeros_q;
`endif

endmodule
